// File: rtl/asm_speed_pkg.sv
// rtl/asm_speed_pkg.sv - shared state encoding and sizing helpers for asm_speed_counter
package asm_speed_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_UP       = 3'd1,
        ST_DN       = 3'd2,
        ST_HOLD     = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_t;

    // Wide enough to hold the largest repeat compare value (delay/period minus two)
    function automatic int timer_width(input int dly, input int per);
        int m;
        m = (dly > per) ? dly : per;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/key_sync2.sv
// rtl/key_sync2.sv - two-flop synchroniser for an asynchronous key input
module key_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic areset,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/asm_speed_counter.sv
// rtl/asm_speed_counter.sv - two-key up/down counter with ASM controller, bounds and auto-repeat
module asm_speed_counter
    import asm_speed_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int MAX_VAL       = 2**WIDTH - 1,
    parameter int WRAP          = 0,
    parameter int REPEAT_EN     = 1,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic             clock,
    input  logic             areset,
    input  logic             key_up_n,
    input  logic             key_dn_n,
    output logic [WIDTH-1:0] count,
    output logic             step,
    output logic             dir,
    output logic             at_max,
    output logic             at_min
);

    localparam int TW = timer_width(REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
    localparam logic [TW-1:0]    DLY_C = TW'(REPEAT_DELAY - 2);
    localparam logic [TW-1:0]    PER_C = TW'(REPEAT_PERIOD - 2);

    if (MAX_VAL < 1 || longint'(MAX_VAL) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_max
        $error("asm_speed_counter: MAX_VAL out of range for WIDTH");
    end
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_repeat
        $error("asm_speed_counter: REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
    end

    logic key_up_s;
    logic key_dn_s;
    logic up;
    logic dn;

    key_sync2 #(.RESET_VAL(1'b1)) u_sync_up (
        .clock  (clock),
        .areset (areset),
        .din    (key_up_n),
        .dout   (key_up_s)
    );

    key_sync2 #(.RESET_VAL(1'b1)) u_sync_dn (
        .clock  (clock),
        .areset (areset),
        .din    (key_dn_n),
        .dout   (key_dn_s)
    );

    assign up = ~key_up_s;
    assign dn = ~key_dn_s;

    state_t        state;
    logic [TW-1:0] timer;
    logic          first;
    logic          hold_up;

    logic             step_en;
    logic             step_up;
    logic [WIDTH-1:0] step_val;
    logic             same_key;
    logic [TW-1:0]    rpt_limit;

    // Next value for a step state; a blocked step at a saturated bound leaves step_en low
    always_comb begin
        step_en  = 1'b0;
        step_up  = 1'b0;
        step_val = count;
        if (state == ST_UP) begin
            step_up = 1'b1;
            if (count != MAX_C) begin
                step_en  = 1'b1;
                step_val = count + 1'b1;
            end else if (WRAP != 0) begin
                step_en  = 1'b1;
                step_val = '0;
            end
        end else if (state == ST_DN) begin
            if (count != '0) begin
                step_en  = 1'b1;
                step_val = count - 1'b1;
            end else if (WRAP != 0) begin
                step_en  = 1'b1;
                step_val = MAX_C;
            end
        end
    end

    assign same_key  = hold_up ? (up && !dn) : (dn && !up);
    assign rpt_limit = first ? DLY_C : PER_C;

    always_ff @(posedge clock or posedge areset) begin
        if (areset) begin
            state   <= ST_IDLE;
            count   <= '0;
            step    <= 1'b0;
            dir     <= 1'b0;
            at_max  <= 1'b0;
            at_min  <= 1'b1;
            timer   <= '0;
            first   <= 1'b0;
            hold_up <= 1'b0;
        end else begin
            step <= step_en;
            if (step_en) begin
                count  <= step_val;
                dir    <= step_up;
                at_max <= (step_val == MAX_C);
                at_min <= (step_val == '0);
            end

            case (state)
                ST_IDLE: begin
                    if (up && !dn) begin
                        state <= ST_UP;
                        first <= 1'b1;
                    end else if (dn && !up) begin
                        state <= ST_DN;
                        first <= 1'b1;
                    end
                end
                ST_UP, ST_DN: begin
                    state   <= ST_HOLD;
                    timer   <= '0;
                    hold_up <= (state == ST_UP);
                end
                ST_HOLD: begin
                    if (!up && !dn) begin
                        state <= ST_IDLE;
                    end else if (same_key) begin
                        // Timer keeps running when repeat is off; wrap-around is harmless then
                        if ((REPEAT_EN != 0) && (timer == rpt_limit)) begin
                            state <= hold_up ? ST_UP : ST_DN;
                            first <= 1'b0;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end else begin
                        state <= ST_WAIT_REL;
                    end
                end
                ST_WAIT_REL: begin
                    if (!up && !dn) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
